seq_multiplier: RTL

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier.sv | 99 +++++++++
 1 files changed

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add unsigned multiplier, one multiplier bit per clock.
// Optional: define SEQ_MULTIPLIER_EARLY_EXIT_EN to finish once the remaining multiplier bits are zero.
module seq_multiplier #(
   parameter int unsigned MAX_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_op,
   input  logic [MAX_WIDTH-1:0]   multiplicand,
   input  logic [MAX_WIDTH-1:0]   multiplier,
   output logic [2*MAX_WIDTH-1:0] product,
   output logic                   busy,
   output logic                   done
);

   localparam int unsigned PW    = 2 * MAX_WIDTH;
   localparam int unsigned CNT_W = $clog2(MAX_WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state, state_next;
   logic [PW-1:0]        mcand_q;
   logic [MAX_WIDTH-1:0] mplier_q;
   logic [PW-1:0]        acc_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [PW-1:0]        acc_next;
   logic                 last_iter;

   always_comb begin
      acc_next = acc_q + ({PW{mplier_q[0]}} & mcand_q);
`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
      // Remaining multiplier bits all zero means no further partial products.
      last_iter = (cnt_q == LAST_CNT) || ((mplier_q >> 1) == '0);
`else
      last_iter = (cnt_q == LAST_CNT);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_op) state_next = CALC;
         CALC:    if (last_iter) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         product  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_op) begin
                  mcand_q  <= {{MAX_WIDTH{1'b0}}, multiplicand};
                  mplier_q <= multiplier;
                  acc_q    <= '0;
                  cnt_q    <= '0;
               end
            end
            CALC: begin
               acc_q    <= acc_next;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 1'b1;
               if (last_iter) begin
                  product <= acc_next;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
